// File: rtl/alu_share_arbiter.sv
// Round-robin time-share of one combinational ALU between the execute stage (port 0)
// and the PC/address sequencer (port 1); one op in flight, registered result returned.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a_in,
  output logic [WIDTH-1:0] alu_b_in,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic             grant1;
  logic             accept;
  logic             owner_rsp_ready;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // req ready depends combinationally on valid (arbitration), never the reverse.
  always_comb begin
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant1 = ~last_grant_q;
    end else begin
      grant1 = req1_valid;
    end
  end

  assign req0_ready      = (state_q == IDLE) && req0_valid && !grant1;
  assign req1_ready      = (state_q == IDLE) && req1_valid && grant1;
  assign accept          = req0_ready || req1_ready;
  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    zero_d       = zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d         = grant1 ? req1_op : req0_op;
          a_d          = grant1 ? req1_a  : req0_a;
          b_d          = grant1 ? req1_b  : req0_b;
          owner_d      = grant1;
          last_grant_d = grant1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_result;
        zero_d   = alu_z;
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
        end else begin
          rsp0_valid_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // last_grant resets to 1 so port 0 wins the first contended arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign alu_a_in    = a_q;
  assign alu_b_in    = b_q;
  assign alu_control = op_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign dbg_state_o = state_q;

endmodule
